// File: rtl/maze_pkg.sv
// Shared constants and types for the 5x5 maze Q-learning datapath.
package maze_pkg;

  localparam int GRID_DIM   = 5;
  localparam int NUM_STATES = 25;
  localparam int GOAL_STATE = 25;
  localparam int Q_W        = 16;

  localparam int NUM_HOLES = 8;
  localparam logic [5:0] HOLES [NUM_HOLES] = '{6'd3, 6'd4, 6'd7, 6'd13, 6'd14, 6'd17, 6'd19, 6'd22};

  localparam logic [3:0] ACT_UP    = 4'b0001;
  localparam logic [3:0] ACT_RIGHT = 4'b0010;
  localparam logic [3:0] ACT_DOWN  = 4'b0100;
  localparam logic [3:0] ACT_LEFT  = 4'b1000;

  typedef enum logic [1:0] {IDLE, READ, WAIT, OUT} sel_state_t;

  function automatic logic [3:0] act_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    act_onehot = ACT_UP;
      2'd1:    act_onehot = ACT_RIGHT;
      2'd2:    act_onehot = ACT_DOWN;
      default: act_onehot = ACT_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/action_selector_if.sv
// Request, Q-table read port and action handshake of the action selector.
interface action_selector_if #(
  parameter int Q_W     = maze_pkg::Q_W,
  parameter int STATE_W = 6,
  parameter int EPS_W   = 8
);
  import maze_pkg::*;

  logic                  start;
  logic [STATE_W-1:0]    state;
  logic [EPS_W-1:0]      epsilon;
  logic                  q_rd_en;
  logic [STATE_W+1:0]    q_rd_addr;
  logic signed [Q_W-1:0] q_rd_data;
  logic [3:0]            action;
  logic                  action_valid;
  logic                  action_ready;
  logic                  explored;
  logic                  illegal;
  logic                  busy;

  modport master (
    input  start, state, epsilon, q_rd_data, action_ready,
    output q_rd_en, q_rd_addr, action, action_valid, explored, illegal, busy
  );

  modport slave (
    output start, state, epsilon, q_rd_data, action_ready,
    input  q_rd_en, q_rd_addr, action, action_valid, explored, illegal, busy
  );

endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 16'hB400) stepping once per advance pulse.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [15:0] value
);
  import maze_pkg::*;

  localparam logic [15:0] TAPS = 16'hB400;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= SEED;
    else if (advance)
      value <= {1'b0, value[15:1]} ^ (value[0] ? TAPS : 16'h0000);
  end

endmodule

// File: rtl/action_selector.sv
// Epsilon-greedy action selector: explores with a legal random move or reads
// the four Q-values of the current state and picks the legal maximum.
module action_selector #(
  parameter int          Q_W       = maze_pkg::Q_W,
  parameter int          STATE_W   = 6,
  parameter int          EPS_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                clk,
  input logic                rst_n,
  action_selector_if.master  bus
);
  import maze_pkg::*;

  sel_state_t fsm, fsm_nx;

  logic [3:0]            mask_q;
  logic [1:0]            idx_q;
  logic                  rd_pend_q;
  logic                  have_max_q;
  logic [3:0]            act_q;
  logic                  expl_q;
  logic                  ill_q;

  logic [STATE_W-1:0]    st_q;
  logic [1:0]            rd_idx_q;
  logic signed [Q_W-1:0] max_q;
  logic [1:0]            max_idx_q;

  logic [STATE_W-1:0]    s0, row, col;
  logic                  state_ok, one_legal, explore_hit, take, accept;
  logic [3:0]            mask_in;
  logic [2:0]            first, nxt;
  logic [1:0]            best_idx;

  logic [15:0]           lfsr_val;
  logic                  lfsr_unused;

  // Lowest legal index at or above lo; bit 2 flags that one exists.
  function automatic logic [2:0] find_from(input logic [3:0] m, input int lo);
    find_from = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (i >= lo && m[i]) find_from = {1'b1, 2'(i)};
  endfunction

  // First legal index starting at base, wrapping upward mod 4.
  function automatic logic [3:0] pick_explore(input logic [3:0] m, input logic [1:0] base);
    logic [1:0] j;
    pick_explore = 4'b0000;
    for (int k = 3; k >= 0; k--) begin
      j = base + 2'(k);
      if (m[j]) pick_explore = act_onehot(j);
    end
  endfunction

  assign accept = (fsm == IDLE) && bus.start;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (accept),
    .value   (lfsr_val)
  );

  assign lfsr_unused = ^lfsr_val[15:10];

  always_comb begin
    state_ok = (bus.state >= STATE_W'(1)) && (bus.state <= STATE_W'(NUM_STATES));
    s0       = bus.state - STATE_W'(1);
    row      = s0 / STATE_W'(GRID_DIM);
    col      = s0 - row * STATE_W'(GRID_DIM);
    mask_in  = 4'b0000;
    if (state_ok)
      mask_in = {col != '0, row != STATE_W'(GRID_DIM - 1), col != STATE_W'(GRID_DIM - 1), row != '0};
    one_legal   = (mask_in != 4'b0000) && ((mask_in & (mask_in - 4'd1)) == 4'b0000);
    explore_hit = lfsr_val[7:0] < bus.epsilon;
    first       = find_from(mask_in, 0);
    nxt         = find_from(mask_q, int'(idx_q) + 1);
    // The first returned value seeds the maximum; strict > keeps the lowest index on ties.
    take        = rd_pend_q && (!have_max_q || (bus.q_rd_data > max_q));
    best_idx    = take ? rd_idx_q : max_idx_q;
  end

  always_comb begin
    fsm_nx = fsm;
    case (fsm)
      IDLE: if (bus.start) fsm_nx = (!state_ok || explore_hit || one_legal) ? OUT : READ;
      READ: if (!nxt[2]) fsm_nx = WAIT;
      WAIT: fsm_nx = OUT;
      OUT:  if (bus.action_ready) fsm_nx = IDLE;
      default: fsm_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      mask_q     <= 4'b0000;
      idx_q      <= 2'd0;
      rd_pend_q  <= 1'b0;
      have_max_q <= 1'b0;
      act_q      <= 4'b0000;
      expl_q     <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      fsm       <= fsm_nx;
      rd_pend_q <= (fsm == READ);
      if (rd_pend_q) have_max_q <= 1'b1;
      case (fsm)
        IDLE: if (bus.start) begin
          mask_q     <= mask_in;
          idx_q      <= first[1:0];
          have_max_q <= 1'b0;
          act_q      <= 4'b0000;
          expl_q     <= 1'b0;
          ill_q      <= 1'b0;
          if (!state_ok) begin
            ill_q <= 1'b1;
          end else if (explore_hit) begin
            act_q  <= pick_explore(mask_in, lfsr_val[9:8]);
            expl_q <= 1'b1;
          end else if (one_legal) begin
            act_q <= mask_in;
          end
        end
        READ: idx_q <= nxt[1:0];
        WAIT: act_q <= act_onehot(best_idx);
        OUT: if (bus.action_ready) begin
          act_q  <= 4'b0000;
          expl_q <= 1'b0;
          ill_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) st_q <= bus.state;
    rd_idx_q <= idx_q;
    if (take) begin
      max_q     <= bus.q_rd_data;
      max_idx_q <= rd_idx_q;
    end
  end

  assign bus.q_rd_en      = (fsm == READ);
  assign bus.q_rd_addr    = (fsm == READ) ? {st_q, idx_q} : '0;
  assign bus.action_valid = (fsm == OUT);
  assign bus.action       = act_q;
  assign bus.explored     = expl_q;
  assign bus.illegal      = ill_q;
  assign bus.busy         = (fsm != IDLE);

endmodule

// File: tb/tb_action_selector.sv
// Directed bench for action_selector with a four-entry Q-table read model.
module tb_action_selector;
  import maze_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic signed [15:0] qtab [4];

  action_selector_if #(.Q_W(16), .STATE_W(6), .EPS_W(8)) bus ();

  action_selector #(.Q_W(16), .STATE_W(6), .EPS_W(8), .LFSR_SEED(16'hACE1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.q_rd_en) bus.q_rd_data <= qtab[bus.q_rd_addr[1:0]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.state = '0;
    bus.epsilon = '0;
    bus.action_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.state = 6'd12;
    bus.epsilon = 8'hFF;
    bus.action_ready = 1'b0;
    step();
    checks++;
    if ({bus.q_rd_en, bus.q_rd_addr, bus.action, bus.action_valid} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b addr=%h act=%b vld=%b exp all zero",
               bus.q_rd_en, bus.q_rd_addr, bus.action, bus.action_valid);
    end
    checks++;
    if ({bus.explored, bus.illegal, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000", {bus.explored, bus.illegal, bus.busy});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_exploit();
    logic [7:0] ea;
    apply_reset();
    qtab[0] = 16'sd5; qtab[1] = -16'sd3; qtab[2] = 16'sd40; qtab[3] = 16'sd40;
    bus.epsilon = 8'h00;
    bus.state = 6'd12;
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.start = 1'b0;
      ea = {6'd12, i[1:0]};
      checks++;
      if (bus.q_rd_en !== 1'b1 || bus.q_rd_addr !== ea || bus.action_valid !== 1'b0) begin
        errors++;
        $display("FAIL exploit_read%0d got en=%b addr=%h vld=%b exp en=1 addr=%h vld=0",
                 i, bus.q_rd_en, bus.q_rd_addr, bus.action_valid, ea);
      end
    end
    step();
    checks++;
    if (bus.q_rd_en !== 1'b0 || bus.action_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL exploit_wait got en=%b vld=%b busy=%b exp 0 0 1",
               bus.q_rd_en, bus.action_valid, bus.busy);
    end
    step();
    checks++;
    if (bus.action_valid !== 1'b1 || bus.action !== ACT_DOWN || bus.explored !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL exploit_action got vld=%b act=%b expl=%b ill=%b exp 1 0100 0 0",
               bus.action_valid, bus.action, bus.explored, bus.illegal);
    end
    bus.action_ready = 1'b1;
    step();
    bus.action_ready = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.action_valid !== 1'b0) begin
      errors++;
      $display("FAIL exploit_release got busy=%b vld=%b exp 0 0", bus.busy, bus.action_valid);
    end
  endtask

  task automatic test_explore();
    apply_reset();
    bus.epsilon = 8'hFF;
    bus.state = 6'd12;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.action_valid !== 1'b1 || bus.action !== ACT_UP || bus.explored !== 1'b1 || bus.q_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL explore_action got vld=%b act=%b expl=%b en=%b exp 1 0001 1 0",
               bus.action_valid, bus.action, bus.explored, bus.q_rd_en);
    end
    bus.action_ready = 1'b1;
    step();
    bus.action_ready = 1'b0;
  endtask

  task automatic test_corner();
    apply_reset();
    qtab[0] = 16'sd100; qtab[1] = -16'sd1; qtab[2] = -16'sd2; qtab[3] = 16'sd100;
    bus.epsilon = 8'h00;
    bus.state = 6'd1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.q_rd_en !== 1'b1 || bus.q_rd_addr !== 8'd5) begin
      errors++;
      $display("FAIL corner_read_right got en=%b addr=%h exp 1 05", bus.q_rd_en, bus.q_rd_addr);
    end
    step();
    checks++;
    if (bus.q_rd_en !== 1'b1 || bus.q_rd_addr !== 8'd6) begin
      errors++;
      $display("FAIL corner_read_down got en=%b addr=%h exp 1 06", bus.q_rd_en, bus.q_rd_addr);
    end
    step();
    checks++;
    if (bus.q_rd_en !== 1'b0 || bus.action_valid !== 1'b0) begin
      errors++;
      $display("FAIL corner_wait got en=%b vld=%b exp 0 0", bus.q_rd_en, bus.action_valid);
    end
    step();
    checks++;
    if (bus.action_valid !== 1'b1 || bus.action !== ACT_RIGHT || bus.explored !== 1'b0) begin
      errors++;
      $display("FAIL corner_action got vld=%b act=%b expl=%b exp 1 0010 0",
               bus.action_valid, bus.action, bus.explored);
    end
    bus.action_ready = 1'b1;
    step();
    bus.action_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [5:0] bad [2];
    bad[0] = 6'd0;
    bad[1] = 6'd30;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      bus.epsilon = (i == 0) ? 8'h00 : 8'hFF;
      bus.state = bad[i];
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checks++;
      if (bus.action_valid !== 1'b1 || bus.action !== 4'b0000 || bus.illegal !== 1'b1 ||
          bus.explored !== 1'b0 || bus.q_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL illegal_state%0d got vld=%b act=%b ill=%b expl=%b en=%b exp 1 0000 1 0 0",
                 bad[i], bus.action_valid, bus.action, bus.illegal, bus.explored, bus.q_rd_en);
      end
      bus.action_ready = 1'b1;
      step();
      bus.action_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.epsilon = 8'hFF;
    bus.state = 6'd12;
    bus.action_ready = 1'b1;
    bus.start = 1'b1;
    step();
    checks++;
    if (bus.action_valid !== 1'b1 || bus.action !== ACT_UP) begin
      errors++;
      $display("FAIL b2b_first got vld=%b act=%b exp 1 0001", bus.action_valid, bus.action);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.action_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got busy=%b vld=%b exp 0 0", bus.busy, bus.action_valid);
    end
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.action_valid !== 1'b1 || bus.action !== ACT_DOWN || bus.explored !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got vld=%b act=%b expl=%b exp 1 0100 1",
               bus.action_valid, bus.action, bus.explored);
    end
    step();
    bus.action_ready = 1'b0;
  endtask

  task automatic test_backpressure_reset();
    apply_reset();
    bus.epsilon = 8'hFF;
    bus.state = 6'd12;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        bus.state = 6'd1;
        bus.epsilon = 8'h00;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      checks++;
      if ({bus.action_valid, bus.action, bus.explored, bus.illegal, bus.q_rd_en} !== 8'b1_0001_1_0_0) begin
        errors++;
        $display("FAIL hold_cycle%0d got vld=%b act=%b expl=%b ill=%b en=%b exp 1 0001 1 0 0",
                 i, bus.action_valid, bus.action, bus.explored, bus.illegal, bus.q_rd_en);
      end
      step();
    end
    bus.start = 1'b0;
    bus.action_ready = 1'b1;
    step();
    bus.action_ready = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.action_valid !== 1'b0 || bus.q_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL not_queued got busy=%b vld=%b en=%b exp 0 0 0",
               bus.busy, bus.action_valid, bus.q_rd_en);
    end
    qtab[0] = 16'sd1; qtab[1] = 16'sd2; qtab[2] = 16'sd3; qtab[3] = 16'sd4;
    bus.epsilon = 8'h00;
    bus.state = 6'd12;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    checks++;
    if (bus.q_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_read got en=%b exp 1", bus.q_rd_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.q_rd_en, bus.q_rd_addr, bus.action, bus.action_valid,
         bus.explored, bus.illegal, bus.busy} !== 17'd0) begin
      errors++;
      $display("FAIL abort_outputs got en=%b addr=%h act=%b vld=%b expl=%b ill=%b busy=%b exp all zero",
               bus.q_rd_en, bus.q_rd_addr, bus.action, bus.action_valid,
               bus.explored, bus.illegal, bus.busy);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (bus.q_rd_en !== 1'b0 || bus.action_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL post_abort%0d got en=%b vld=%b busy=%b exp 0 0 0",
                 i, bus.q_rd_en, bus.action_valid, bus.busy);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.state = '0;
    bus.epsilon = '0;
    bus.action_ready = 1'b0;
    for (int i = 0; i < 4; i++) qtab[i] = '0;
    test_reset();
    test_exploit();
    test_explore();
    test_corner();
    test_illegal();
    test_back_to_back();
    test_backpressure_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/action_selector.md
# action_selector

Epsilon-greedy action selector for the 5x5 maze Q-learning datapath. Given the agent's current state, it either explores with a legal pseudo-random action or exploits by reading the four Q-values for that state from the Q-table read port and choosing the legal maximum. It sits directly upstream of the state selector and produces the one-hot `next_action` that the state selector consumes. It also owns move legality at the grid edges, so the state selector never receives an off-grid move.

## Interface
Parameters:
- `Q_W`, 16: Q-value width, signed, matching the reward width.
- `STATE_W`, 6: state index width.
- `EPS_W`, 8: epsilon threshold width.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request pulse; accepted only in IDLE.
- `state`  in  STATE_W: current state (1..25, row-major, 1 = top-left, 25 = goal); sampled on the accepted `start`.
- `epsilon`  in  EPS_W: explore when `lfsr[7:0] < epsilon`; sampled on the accepted `start`.
- `q_rd_en`  out  1: Q-table read strobe.
- `q_rd_addr`  out  STATE_W+2: read address `{state, idx[1:0]}`.
- `q_rd_data`  in  Q_W: signed data, valid exactly 1 cycle after `q_rd_en`.
- `action`  out  4: one-hot. bit0 up, bit1 right, bit2 down, bit3 left.
- `action_valid`  out  1: `action` is valid.
- `action_ready`  in  1: consumer accepts the action.
- `explored`  out  1: the held action came from the explore path.
- `illegal`  out  1: `state` was outside 1..25.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, READ, WAIT, OUT.
- IDLE → OUT when `start` is accepted and any of these holds:
  - explore is chosen;
  - the state is illegal;
  - exactly one action is legal.
  Otherwise IDLE → READ.
- READ: one cycle per legal index, in ascending order. Assert `q_rd_en` with `q_rd_addr = {state, idx}`. After the last legal index, go to WAIT.
- WAIT: one cycle to capture the final data, then go to OUT.
- OUT: hold `action_valid`, `action`, `explored` and `illegal` stable until `action_ready`. When `action_ready` is seen, go to IDLE.
- Legality masks, with r = (state-1)/5 and c = (state-1)%5:
  - up is illegal when r = 0;
  - down is illegal when r = 4;
  - left is illegal when c = 0;
  - right is illegal when c = 4.
- Exploit path:
  - Running maximum uses a signed compare over legal indices only.
  - Strict greater-than, so ties resolve to the lowest index.
  - The first legal value initialises the maximum, so -32768 is handled correctly.
- Explore path:
  - Candidate index = `lfsr[9:8]`.
  - If the candidate is illegal, increment it mod 4 until it is legal. The search is combinational and takes at most 2 steps.
- Illegal state: `action` = 4'b0000, `illegal` = 1, `explored` = 0. No reads are issued.
- LFSR:
  - 16-bit Galois, taps 16'hB400.
  - Advances exactly once per accepted `start`, using the value present before the advance.
  - This makes the action sequence deterministic for a given seed.
- `start` while `busy` is ignored. It is not queued.

## Timing
- Reset values: all outputs 0, FSM in IDLE, LFSR = LFSR_SEED.
- Asserting `rst_n` low mid-operation aborts immediately. Any in-flight read is discarded and no action is produced.
- Latency, measured from the `start` cycle (cycle 0) to `action_valid`:
  - explore, illegal, or single-legal-action: cycle 1;
  - exploit with n legal actions: reads in cycles 1..n, `action_valid` in cycle n+2 (cycle 6 for an interior state).
- `action_valid` with `action_ready` high in the same cycle:
  - the action transfers;
  - IDLE is entered next cycle;
  - a new `start` is accepted the cycle after that.
- `q_rd_en` is never asserted outside READ.

## Structure
- Shared `maze_pkg` holds:
  - GRID_DIM = 5, NUM_STATES = 25, GOAL_STATE = 25;
  - the hole list 3, 4, 7, 13, 14, 17, 19, 22;
  - one-hot action constants ACT_UP, ACT_RIGHT, ACT_DOWN, ACT_LEFT;
  - Q_W.
- One sub-module: `lfsr16`, with seed parameter, `advance` enable, and 16-bit value output.
- The legality mask and the compare logic stay inline in `action_selector`.

## Test plan
- Exploit at an interior state: reset, `epsilon` = 0, `start` with `state` = 12, Q-values for up/right/down/left = 5, -3, 40, 40.
  - Reads at addresses {12,0}..{12,3} in cycles 1..4.
  - Cycle 6: `action` = 4'b0100 (down wins the tie with left), `explored` = 0.
- Explore: reset, `epsilon` = 8'hFF, `state` = 12.
  - LFSR value 0xACE1 gives 8'hE1 < 8'hFF and candidate index 0.
  - Cycle 1: `action` = 4'b0001, `explored` = 1, no `q_rd_en`.
- Corner masking: exploit at `state` = 1 with Q up/right/down/left = 100, -1, -2, 100.
  - Only index 1 and index 2 are read.
  - Result: `action` = 4'b0010.
- Illegal state: `start` with `state` = 0, then with `state` = 30.
  - Both give `action_valid` at cycle 1 with `action` = 0, `illegal` = 1.
- Backpressure and reset: hold `action_ready` low for 10 cycles, then pulse `start`.
  - Outputs stay stable throughout and the extra `start` is ignored.
  - Assert `rst_n` low during a later READ: all outputs are 0 on the same edge and no stray `q_rd_en` follows.
